// File: rtl/tlight_pkg.sv
// Shared light-code constants and pedestrian phase states for the intersection
// controller and the pedestrian crossing block.
package tlight_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        FLASH
    } ped_state_t;

    function automatic logic is_legal_code(input logic [2:0] code);
        return (code == RED) || (code == YELLOW) || (code == GREEN);
    endfunction

endpackage

// File: rtl/ped_channel.sv
// One pedestrian crossing: button synchronizer, request latch, green-rise
// detection and the WALK / FLASH phase sequencer with lamp decode.
module ped_channel
    import tlight_pkg::*;
#(
    parameter int WALK_TIME  = 7,
    parameter int FLASH_TIME = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_btn,
    input  logic [2:0] i_light,
    input  logic       i_force_idle,
    output logic       o_walk,
    output logic       o_dontwalk,
    output logic       o_wait,
    output logic [3:0] o_count
);

    localparam logic [3:0] WALK_LOAD  = 4'(WALK_TIME - 1);
    localparam logic [3:0] FLASH_LOAD = 4'(FLASH_TIME - 1);

    logic [1:0] r_sync;
    logic       r_req;
    logic       r_prev_green;
    logic       r_blink;
    logic [3:0] r_cnt;
    ped_state_t r_state;

    ped_state_t w_state_next;
    logic [3:0] w_cnt_next;
    logic       w_blink_next;
    logic       w_req_next;
    logic       w_green;
    logic       w_start;

    assign w_green = (i_light == GREEN);

    // A phase only starts on the first green cycle, so mid-green presses wait.
    assign w_start = (r_state == IDLE) && w_green && !r_prev_green && r_req && !i_force_idle;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync       <= 2'b00;
            r_req        <= 1'b0;
            r_prev_green <= 1'b0;
            r_blink      <= 1'b0;
            r_cnt        <= 4'd0;
            r_state      <= IDLE;
        end else begin
            r_sync       <= {r_sync[0], i_btn};
            r_req        <= w_req_next;
            r_prev_green <= w_green;
            r_blink      <= w_blink_next;
            r_cnt        <= w_cnt_next;
            r_state      <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_blink_next = r_blink;
        w_req_next   = r_req;

        if (w_start) begin
            w_req_next = 1'b0;
        end else if (r_sync[1] && (r_state != WALK)) begin
            w_req_next = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = WALK;
                    w_cnt_next   = WALK_LOAD;
                    w_blink_next = 1'b0;
                end
            end
            WALK: begin
                if (!w_green) begin
                    w_state_next = IDLE;
                    w_cnt_next   = 4'd0;
                end else if (r_cnt == 4'd0) begin
                    w_state_next = FLASH;
                    w_cnt_next   = FLASH_LOAD;
                    w_blink_next = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            FLASH: begin
                if (!w_green || (r_cnt == 4'd0)) begin
                    w_state_next = IDLE;
                    w_cnt_next   = 4'd0;
                    w_blink_next = 1'b0;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                    w_blink_next = !r_blink;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 4'd0;
                w_blink_next = 1'b0;
            end
        endcase

        // A light-code fault overrides any phase in progress.
        if (i_force_idle) begin
            w_state_next = IDLE;
            w_cnt_next   = 4'd0;
            w_blink_next = 1'b0;
        end
    end

    assign o_walk     = (r_state == WALK);
    assign o_dontwalk = (r_state == IDLE) || ((r_state == FLASH) && r_blink);
    assign o_wait     = r_req;
    assign o_count    = (r_state == FLASH) ? (r_cnt + 4'd1) : 4'd0;

endmodule

// File: rtl/ped_signal.sv
// Pedestrian crossing controller: two independent crossings fed by the vehicle
// light codes, plus a sticky fault that parks both crossings on illegal codes.
module ped_signal
    import tlight_pkg::*;
#(
    parameter int WALK_TIME  = 7,
    parameter int FLASH_TIME = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] ns,
    input  logic [2:0] we,
    input  logic       btn_ns,
    input  logic       btn_we,
    output logic       walk_ns,
    output logic       walk_we,
    output logic       dontwalk_ns,
    output logic       dontwalk_we,
    output logic       wait_ns,
    output logic       wait_we,
    output logic [3:0] count_ns,
    output logic [3:0] count_we,
    output logic       fault
);

    logic r_fault;
    logic w_illegal;
    logic w_force_idle;

    assign w_illegal = !is_legal_code(ns) || !is_legal_code(we) ||
                       ((ns == GREEN) && (we == GREEN));

    // The illegal code itself must already park the channels on the edge the
    // fault is registered, hence the combinational term alongside r_fault.
    assign w_force_idle = r_fault || w_illegal;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fault <= 1'b0;
        end else if (w_illegal) begin
            r_fault <= 1'b1;
        end
    end

    assign fault = r_fault;

    ped_channel #(
        .WALK_TIME  (WALK_TIME),
        .FLASH_TIME (FLASH_TIME)
    ) u_ch_ns (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_btn        (btn_ns),
        .i_light      (ns),
        .i_force_idle (w_force_idle),
        .o_walk       (walk_ns),
        .o_dontwalk   (dontwalk_ns),
        .o_wait       (wait_ns),
        .o_count      (count_ns)
    );

    ped_channel #(
        .WALK_TIME  (WALK_TIME),
        .FLASH_TIME (FLASH_TIME)
    ) u_ch_we (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_btn        (btn_we),
        .i_light      (we),
        .i_force_idle (w_force_idle),
        .o_walk       (walk_we),
        .o_dontwalk   (dontwalk_we),
        .o_wait       (wait_we),
        .o_count      (count_we)
    );

endmodule

// File: tb/tb_ped_signal.sv
// Bench for ped_signal: directed scenarios plus randomized intersection cycles,
// all checked against a phase-age reference model of the crossings.
module tb_ped_signal;
    import tlight_pkg::*;

    localparam int W = 7;
    localparam int F = 6;

    logic       clock;
    logic       reset_n;
    logic [2:0] ns;
    logic [2:0] we;
    logic       btn_ns;
    logic       btn_we;
    logic       walk_ns, walk_we, dontwalk_ns, dontwalk_we, wait_ns, wait_we, fault;
    logic [3:0] count_ns, count_we;

    int errors = 0;
    int checks = 0;

    // Reference model: a crossing is either inactive or "active" for a number
    // of cycles (age) since its WALK began; lamps follow from the age alone.
    bit m_s1[2];
    bit m_s2[2];
    bit m_req[2];
    bit m_prev[2];
    bit m_active[2];
    int m_age[2];
    bit m_fault;

    ped_signal #(
        .WALK_TIME  (W),
        .FLASH_TIME (F)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ns          (ns),
        .we          (we),
        .btn_ns      (btn_ns),
        .btn_we      (btn_we),
        .walk_ns     (walk_ns),
        .walk_we     (walk_we),
        .dontwalk_ns (dontwalk_ns),
        .dontwalk_we (dontwalk_we),
        .wait_ns     (wait_ns),
        .wait_we     (wait_we),
        .count_ns    (count_ns),
        .count_we    (count_we),
        .fault       (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit legal(input logic [2:0] c);
        return (c == RED) || (c == YELLOW) || (c == GREEN);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_req[c] = 0;
            m_prev[c] = 0; m_active[c] = 0; m_age[c] = 0;
        end
        m_fault = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit illegal, force_idle, green, in_walk, start;
        logic [2:0] light;
        logic btn;
        illegal    = !legal(ns) || !legal(we) || (ns == GREEN && we == GREEN);
        force_idle = m_fault || illegal;
        for (int c = 0; c < 2; c++) begin
            light   = (c == 0) ? ns : we;
            btn     = (c == 0) ? btn_ns : btn_we;
            green   = (light == GREEN);
            in_walk = m_active[c] && (m_age[c] < W);
            start   = !m_active[c] && green && !m_prev[c] && m_req[c] && !force_idle;
            if (start) m_req[c] = 0;
            else if (m_s2[c] && !in_walk) m_req[c] = 1;
            if (m_active[c]) begin
                if (force_idle || !green || (m_age[c] + 1 >= W + F)) m_active[c] = 0;
                else m_age[c] = m_age[c] + 1;
            end else if (start) begin
                m_active[c] = 1;
                m_age[c]    = 0;
            end
            m_prev[c] = green;
            m_s2[c]   = m_s1[c];
            m_s1[c]   = btn;
        end
        if (illegal) m_fault = 1;
    endtask

    function automatic logic [14:0] model_vec();
        logic [6:0] ch [2];
        bit walk, flash, dw;
        logic [3:0] cnt;
        for (int c = 0; c < 2; c++) begin
            walk  = m_active[c] && (m_age[c] < W);
            flash = m_active[c] && (m_age[c] >= W);
            dw    = !m_active[c] ? 1'b1 : (flash ? ((m_age[c] - W) % 2 == 0) : 1'b0);
            cnt   = flash ? 4'(W + F - m_age[c]) : 4'd0;
            ch[c] = {walk, dw, m_req[c], cnt};
        end
        return {ch[0], ch[1], m_fault};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {walk_ns, dontwalk_ns, wait_ns, count_ns,
                walk_we, dontwalk_we, wait_we, count_we, fault};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ns = RED; we = RED; btn_ns = 1'b0; btn_we = 1'b0;
        model_reset();
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== {7'b0100000, 7'b0100000, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_idle: dut=%h required=%h", dut_vec(), {7'b0100000, 7'b0100000, 1'b0});
        end
        btn_ns = 1'b1; tick(); btn_ns = 1'b0; tick(); tick();
        ns = GREEN;
        repeat (3) tick();
        checks++;
        if (walk_ns !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_prewalk: walk_ns=%b required=1", walk_ns);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({walk_ns, dontwalk_ns, wait_ns, count_ns, fault} !== {1'b0, 1'b1, 1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_midwalk: dut=%b required=0100000", {walk_ns, dontwalk_ns, wait_ns, count_ns, fault});
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("[TB] FAIL reset_model: dut=%h model=%h", dut_vec(), model_vec());
        end
        ns = RED;
        reset_n = 1'b1;
    endtask

    task automatic test_served_request();
        int walks;
        do_reset();
        btn_ns = 1'b1; tick(); btn_ns = 1'b0;
        tick(); tick();
        checks++;
        if (wait_ns !== 1'b1) begin
            errors++;
            $display("[TB] FAIL served_wait: wait_ns=%b required=1", wait_ns);
        end
        ns = GREEN;
        walks = 0;
        for (int i = 0; i < W; i++) begin
            tick();
            if (walk_ns === 1'b1) walks++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL served_walk_model: dut=%h model=%h", dut_vec(), model_vec());
            end
        end
        checks++;
        if (walks != W || wait_ns !== 1'b0) begin
            errors++;
            $display("[TB] FAIL served_walk: walks=%0d wait=%b required=%0d,0", walks, wait_ns, W);
        end
        for (int i = 0; i < F; i++) begin
            tick();
            checks++;
            if ({walk_ns, dontwalk_ns, count_ns} !== {1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, 4'(F - i)}) begin
                errors++;
                $display("[TB] FAIL served_flash%0d: dw=%b count=%0d required=%0d,%0d",
                         i, dontwalk_ns, count_ns, (i % 2 == 0), F - i);
            end
        end
        tick();
        checks++;
        if ({walk_ns, dontwalk_ns, count_ns} !== {1'b0, 1'b1, 4'd0}) begin
            errors++;
            $display("[TB] FAIL served_stop: walk=%b dw=%b count=%0d required=0,1,0", walk_ns, dontwalk_ns, count_ns);
        end
        ns = YELLOW; tick();
        ns = RED; tick();
    endtask

    task automatic test_late_request();
        bit seen;
        do_reset();
        ns = GREEN;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            btn_ns = (i == 4);
            tick();
            if (walk_ns === 1'b1) seen = 1;
        end
        btn_ns = 1'b0;
        checks++;
        if (seen || wait_ns !== 1'b1) begin
            errors++;
            $display("[TB] FAIL late_hold: walked=%b wait=%b required=0,1", seen, wait_ns);
        end
        ns = YELLOW; repeat (3) tick();
        ns = RED;    repeat (3) tick();
        ns = GREEN;  tick();
        checks++;
        if (walk_ns !== 1'b1) begin
            errors++;
            $display("[TB] FAIL late_served: walk_ns=%b required=1", walk_ns);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("[TB] FAIL late_model: dut=%h model=%h", dut_vec(), model_vec());
        end
        ns = RED; tick();
    endtask

    task automatic test_truncation();
        do_reset();
        btn_ns = 1'b1; tick(); btn_ns = 1'b0; tick(); tick();
        ns = GREEN;
        repeat (3) tick();
        ns = YELLOW;
        tick();
        checks++;
        if ({walk_ns, dontwalk_ns, count_ns, fault} !== {1'b0, 1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL truncate: walk=%b dw=%b count=%0d fault=%b required=0,1,0,0",
                     walk_ns, dontwalk_ns, count_ns, fault);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("[TB] FAIL truncate_model: dut=%h model=%h", dut_vec(), model_vec());
        end
        ns = RED; tick();
    endtask

    task automatic test_fault();
        do_reset();
        btn_we = 1'b1; tick(); btn_we = 1'b0; tick(); tick();
        we = GREEN;
        tick(); tick();
        checks++;
        if (walk_we !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fault_prewalk: walk_we=%b required=1", walk_we);
        end
        ns = 3'b011;
        tick();
        checks++;
        if ({fault, walk_we, dontwalk_we, walk_ns, dontwalk_ns} !== 5'b10101) begin
            errors++;
            $display("[TB] FAIL fault_set: dut=%b required=10101", {fault, walk_we, dontwalk_we, walk_ns, dontwalk_ns});
        end
        ns = RED; we = RED;
        btn_ns = 1'b1; tick(); btn_ns = 1'b0;
        tick(); tick();
        we = GREEN; tick(); tick();
        checks++;
        if (dut_vec() !== model_vec() || fault !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fault_sticky: dut=%h model=%h", dut_vec(), model_vec());
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (fault !== 1'b0 || dut_vec() !== model_vec()) begin
            errors++;
            $display("[TB] FAIL fault_clear: dut=%h model=%h", dut_vec(), model_vec());
        end
        we = RED;
        reset_n = 1'b1;
    endtask

    task automatic run_phase(input logic [2:0] n, input logic [2:0] w, input int len);
        ns = n;
        we = w;
        for (int i = 0; i < len; i++) begin
            btn_ns = ($urandom_range(0, 4) == 0);
            btn_we = ($urandom_range(0, 4) == 0);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL random_model: dut=%h model=%h ns=%b we=%b", dut_vec(), model_vec(), ns, we);
            end
            checks++;
            if ((walk_ns && walk_we) || (walk_ns && ns !== GREEN) || (walk_we && we !== GREEN)) begin
                errors++;
                $display("[TB] FAIL random_overlap: walk_ns=%b walk_we=%b ns=%b we=%b required=own_green_only",
                         walk_ns, walk_we, ns, we);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int r = 0; r < 8; r++) begin
            run_phase(GREEN, RED, $urandom_range(3, 18));
            run_phase(YELLOW, RED, 2);
            run_phase(RED, GREEN, $urandom_range(3, 18));
            run_phase(RED, YELLOW, 2);
        end
        btn_ns = 1'b0;
        btn_we = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        ns = RED; we = RED; btn_ns = 1'b0; btn_we = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_served_request();
        test_late_request();
        test_truncation();
        test_fault();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
